fifo_ptr_ctrl: RTL and testbench
================================

// Module: fifo_ptr_ctrl
// PURPOSE
//  - Pointer/flag controller that sequences the 2**AWIDTH-entry mem_data array as a FIFO.
//  - Generates wr_ptr/rd_ptr plus full, empty, almost and error flags for SpaceWire TX/RX buffers.
//  - mem_data writes data_in to MEM[wr_ptr] on every clock, and reads MEM[rd_ptr] combinationally.
//  - Therefore this block keeps wr_ptr on a free slot at all times.
//  - Usable capacity is 2**AWIDTH-1 entries (63 at default).
// PARAMETERS
//  AWIDTH     6   pointer width; memory depth 2**AWIDTH, capacity 2**AWIDTH-1
//  AFULL_TH   56  almost_full asserted when count >= AFULL_TH
//  AEMPTY_TH  4   almost_empty asserted when count <= AEMPTY_TH
// PORTS
//  clock         in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-low reset
//  flush         in   1       synchronous clear of pointers, count and error flags
//  wr_en         in   1       write request; data on mem_data data_in this cycle
//  rd_en         in   1       read request; consumer takes mem_data data_out this cycle
//  wr_ptr        out  AWIDTH  write address to mem_data
//  rd_ptr        out  AWIDTH  read address to mem_data
//  count         out  AWIDTH  number of stored entries, 0..2**AWIDTH-1
//  full          out  1       count == 2**AWIDTH-1
//  empty         out  1       count == 0
//  almost_full   out  1       count >= AFULL_TH
//  almost_empty  out  1       count <= AEMPTY_TH
//  wr_ack        out  1       registered: write accepted in previous cycle
//  overflow      out  1       sticky: wr_en seen while full
//  underflow     out  1       sticky: rd_en seen while empty
// BEHAVIOUR
//  - Reset: sampled on the rising clock edge while reset==0. It overrides all other inputs.
//    - wr_ptr=0, rd_ptr=0, count=0.
//    - empty=1, almost_empty=1, full=0, almost_full=0.
//    - wr_ack=0, overflow=0, underflow=0.
//  - All outputs are registered. Flags are computed from next-state count, so they are valid in the same cycle as count.
//  - Acceptance:
//    - wr_acc = wr_en & ~full.
//    - rd_acc = rd_en & ~empty.
//    - Decisions use the current registered flags only.
//  - wr_acc: the data_in word lands in MEM[wr_ptr] at this edge; wr_ptr <= wr_ptr+1.
//  - rd_acc: the consumer samples data_out (MEM[rd_ptr]) this cycle; rd_ptr <= rd_ptr+1.
//  - Read is first-word fall-through with zero cycles read latency.
//  - Written data is visible on data_out one cycle after wr_acc, when the FIFO was empty.
//  - Pointers wrap modulo 2**AWIDTH (63 -> 0), with no extra wrap bit. Full/empty come from count.
//  - count update:
//    - +1 on wr_acc only.
//    - -1 on rd_acc only.
//    - Unchanged when both or neither are accepted.
//  - Simultaneous wr_en & rd_en:
//    - Full: read accepted, write rejected; count becomes 62; overflow set.
//    - Empty: write accepted, read rejected; count becomes 1; underflow set.
//    - Otherwise: both accepted, count unchanged.
//  - Since count <= 2**AWIDTH-2 whenever a write is accepted, wr_ptr never equals the rd_ptr slot that holds live data.
//    - This makes the unconditional memory write harmless.
//  - wr_ack <= wr_acc; it is cleared by flush.
//  - overflow and underflow stay set until reset or flush.
//  - flush (reset==1):
//    - Same values as reset for every output.
//    - flush has priority over wr_en and rd_en in the same cycle.
//    - Memory contents are untouched.
//  - Reset or flush mid-burst: in-flight requests that cycle are dropped. The next cycle starts from the empty state.
// TESTING
//  - Reset with wr_en=rd_en=1 held -> all pointers 0, empty=1, wr_ack=0, no overflow/underflow.
//  - 63 writes of 0x100+i, rd_en=0 -> full=1 after the 63rd, count=63, wr_ptr=63, almost_full from count 56.
//    - A 64th write gives wr_ack=0 and overflow=1.
//  - Then 63 reads -> data_out returns 0x100..0x13E in order, empty=1, rd_ptr=63.
//    - An extra read sets underflow=1.
//  - Wrap: 100 cycles of wr_en=rd_en=1 after 1 preload, incrementing data -> count stays 1, pointers wrap 63->0, data in order.
//  - Full plus simultaneous wr/rd -> count 63->62, overflow=1.
//    - Empty plus simultaneous wr/rd -> count 0->1, underflow=1, written word on data_out the next cycle.
//  - flush at count=20 with wr_en=1 -> next cycle count=0, ptrs=0, empty=1, errors cleared, wr_ack=0.

Source files
------------

// File: rtl/fifo_ptr_ctrl_if.sv
// Control/status bundle between a FIFO user and fifo_ptr_ctrl.
// The master side issues write/read/flush requests, and the slave side reports pointers and flags.
interface fifo_ptr_ctrl_if #(
  parameter int AWIDTH = 6
);
  logic              flush;
  logic              wr_en;
  logic              rd_en;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, rd_en,
    input  wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           wr_ack, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, rd_en,
    output wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           wr_ack, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag sequencer for a 2**AWIDTH-entry write-every-cycle memory used as a FIFO.
// Every output is registered, and the flags are derived from the next-state count.
module fifo_ptr_ctrl #(
  parameter int AWIDTH    = 6,
  parameter int AFULL_TH  = 56,
  parameter int AEMPTY_TH = 4
) (
  input  logic            clock,
  input  logic            reset,
  fifo_ptr_ctrl_if.slave  bus
);

  localparam logic [AWIDTH-1:0] CAP       = '1;
  localparam logic [AWIDTH-1:0] ONE       = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] AFULL_C   = AWIDTH'(AFULL_TH);
  localparam logic [AWIDTH-1:0] AEMPTY_C  = AWIDTH'(AEMPTY_TH);

  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              wr_ack_q, overflow_q, underflow_q;
  logic              wr_acc, rd_acc;

  // Acceptance looks only at the registered flags. A full FIFO therefore refuses a write
  // even when a read in the same cycle would make room for it.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset || bus.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ONE;
      count_q     <= count_d;
      full_q      <= (count_d == CAP);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AFULL_C);
      aempty_q    <= (count_d <= AEMPTY_C);
      wr_ack_q    <= wr_acc;
      overflow_q  <= overflow_q  | (bus.wr_en & full_q);
      underflow_q <= underflow_q | (bus.rd_en & empty_q);
    end
  end

  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl. A queue-based FIFO model and a model of the
// write-every-cycle memory are checked against the DUT on every cycle.
module tb_fifo_ptr_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] mem [64];

  int checks   = 0;
  int failures = 0;

  fifo_ptr_ctrl_if #(.AWIDTH(6)) bus ();

  fifo_ptr_ctrl #(.AWIDTH(6), .AFULL_TH(56), .AEMPTY_TH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words, pointer counters modulo 64, and sticky error bits.
  logic [15:0] m_q [$];
  int          m_wp = 0, m_rp = 0;
  bit          m_ack = 0, m_ovf = 0, m_unf = 0, started = 0;
  logic [5:0]  dut_wp_s = '0;

  // The memory writes data_in at the DUT's current write pointer on every clock edge.
  always @(negedge clock) dut_wp_s = bus.wr_ptr;

  always @(posedge clock) begin : model
    bit m_full, m_empty, wa, ra;
    mem[dut_wp_s] = data_in;
    if (!reset || bus.flush) begin
      m_q.delete();
      m_wp = 0; m_rp = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
      if (!reset) started = 1;
    end else begin
      m_full  = (m_q.size() == 63);
      m_empty = (m_q.size() == 0);
      wa = bus.wr_en && !m_full;
      ra = bus.rd_en && !m_empty;
      if (bus.wr_en && m_full)  m_ovf = 1;
      if (bus.rd_en && m_empty) m_unf = 1;
      if (ra) begin
        void'(m_q.pop_front());
        m_rp = (m_rp + 1) % 64;
      end
      if (wa) begin
        m_q.push_back(data_in);
        m_wp = (m_wp + 1) % 64;
      end
      m_ack = wa;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("count",        32'(bus.count),        32'(m_q.size()));
      check("wr_ptr",       32'(bus.wr_ptr),       32'(m_wp));
      check("rd_ptr",       32'(bus.rd_ptr),       32'(m_rp));
      check("full",         32'(bus.full),         32'(m_q.size() == 63));
      check("empty",        32'(bus.empty),        32'(m_q.size() == 0));
      check("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= 56));
      check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= 4));
      check("wr_ack",       32'(bus.wr_ack),       32'(m_ack));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
      if (reset && !bus.flush && bus.rd_en && m_q.size() > 0)
        check("data_out", 32'(mem[bus.rd_ptr]), 32'(m_q[0]));
    end
  end

  task automatic drive(input bit w, input bit r, input bit f, input logic [15:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.flush = f;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.flush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_wr_ptr",    32'(bus.wr_ptr),    32'd0);
    check("rst_empty",     32'(bus.empty),     32'd1);
    check("rst_wr_ack",    32'(bus.wr_ack),    32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // Fill to capacity.
    for (int i = 0; i < 63; i++) begin
      drive(1, 0, 0, 16'(16'h100 + i));
      if (i == 54) check("afull_at_55", 32'(bus.almost_full), 32'd0);
      if (i == 55) check("afull_at_56", 32'(bus.almost_full), 32'd1);
    end
    check("fill_count",  32'(bus.count),  32'd63);
    check("fill_full",   32'(bus.full),   32'd1);
    check("fill_wr_ptr", 32'(bus.wr_ptr), 32'd63);
    drive(1, 0, 0, 16'h1FF);
    check("ovf_wr_ack",   32'(bus.wr_ack),   32'd0);
    check("ovf_overflow", 32'(bus.overflow), 32'd1);

    // Drain everything, then make one extra read.
    check("first_word", 32'(mem[bus.rd_ptr]), 32'h100);
    for (int i = 0; i < 63; i++) begin
      if (i == 62) check("last_word", 32'(mem[bus.rd_ptr]), 32'h13E);
      drive(0, 1, 0, 16'h0);
    end
    check("drain_empty",  32'(bus.empty),  32'd1);
    check("drain_rd_ptr", 32'(bus.rd_ptr), 32'd63);
    drive(0, 1, 0, 16'h0);
    check("unf_underflow", 32'(bus.underflow), 32'd1);

    // Flush, then stream writes and reads together so both pointers wrap.
    drive(0, 0, 1, 16'h0);
    check("flush_ovf", 32'(bus.overflow),  32'd0);
    check("flush_unf", 32'(bus.underflow), 32'd0);
    drive(1, 0, 0, 16'h200);
    for (int i = 0; i < 100; i++) drive(1, 1, 0, 16'(16'h201 + i));
    check("wrap_count",  32'(bus.count),  32'd1);
    check("wrap_wr_ptr", 32'(bus.wr_ptr), 32'd37);
    check("wrap_rd_ptr", 32'(bus.rd_ptr), 32'd36);

    // Simultaneous write and read while full.
    drive(0, 0, 1, 16'h0);
    for (int i = 0; i < 63; i++) drive(1, 0, 0, 16'(16'h300 + i));
    drive(1, 1, 0, 16'h3FF);
    check("fullrw_count", 32'(bus.count),    32'd62);
    check("fullrw_ovf",   32'(bus.overflow), 32'd1);
    check("fullrw_full",  32'(bus.full),     32'd0);

    // Simultaneous write and read while empty.
    drive(0, 0, 1, 16'h0);
    drive(1, 1, 0, 16'hABC);
    check("emptyrw_count", 32'(bus.count),      32'd1);
    check("emptyrw_unf",   32'(bus.underflow),  32'd1);
    check("emptyrw_data",  32'(mem[bus.rd_ptr]), 32'hABC);

    // Flush at count 20 while a write is requested.
    drive(0, 0, 1, 16'h0);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 16'(16'h400 + i));
    drive(1, 0, 1, 16'h555);
    check("fl20_count",  32'(bus.count),  32'd0);
    check("fl20_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    check("fl20_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    check("fl20_empty",  32'(bus.empty),  32'd1);
    check("fl20_wr_ack", 32'(bus.wr_ack), 32'd0);

    // Random traffic with shifting bias, occasional flushes, and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      case ((i / 300) % 4)
        0:       pw = 80;
        1:       pw = 20;
        2:       pw = 50;
        default: pw = 95;
      endcase
      if (i == 1500) reset = 1'b0;
      drive($urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 199) == 0,
            16'($urandom));
      if (i == 1500) reset = 1'b1;
    end

    drive(0, 0, 0, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
